// File: rtl/demux_4ch_reg_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
// Mode codes, source-side FSM states and slot indices.
package demux_4ch_reg_pkg;

    localparam logic MODE_ADDR  = 1'b0;
    localparam logic MODE_BCAST = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int unsigned SLOT_DISP = 0;
    localparam int unsigned SLOT_FLAG = 1;
    localparam int unsigned SLOT_ACC  = 2;
    localparam int unsigned SLOT_DBG  = 3;

endpackage

// File: rtl/demux_4ch_reg_slot_reg.sv
// One-entry holding register with a valid/ready output handshake.
// A fill in the same cycle as a drain keeps the slot valid (zero bubble).
module slot_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fill,
    input  logic [W-1:0] fill_data,
    input  logic         out_ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         free
);

    logic [W-1:0] r_data;
    logic         r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (fill) begin
            r_data  <= fill_data;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign free  = !r_valid || out_ready;

endmodule

// File: rtl/demux_4ch_reg.sv
// Registered 1-to-4 demux: addressed or broadcast writes into four slots,
// with an accept counter and a sticky source-protocol error flag.
module demux_4ch_reg
    import demux_4ch_reg_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [W-1:0]     IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       SEL,
    input  logic             MODE,
    output logic [W-1:0]     OUT_DATA0,
    output logic [W-1:0]     OUT_DATA1,
    output logic [W-1:0]     OUT_DATA2,
    output logic [W-1:0]     OUT_DATA3,
    output logic [3:0]       OUT_VALID,
    input  logic [3:0]       OUT_READY,
    output logic [CNT_W-1:0] ACC_CNT,
    output logic             PROT_ERR
);

    logic [3:0]   w_free;
    logic [3:0]   w_fill;
    logic [3:0]   w_valid;
    logic [W-1:0] w_data [4];
    logic         w_bcast;
    logic         w_in_ready;
    logic         w_accept;
    logic         w_mismatch;
    logic         w_capture;
    logic         w_err_set;
    state_t       w_state_nxt;

    state_t           r_state;
    logic [W-1:0]     r_hold_data;
    logic [1:0]       r_hold_sel;
    logic             r_hold_mode;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             r_prot_err;

    assign w_bcast    = (MODE == MODE_BCAST);
    assign w_in_ready = !RST && (w_bcast ? &w_free : w_free[SEL]);
    assign w_accept   = IN_VALID && w_in_ready;

    for (genvar k = 0; k < 4; k++) begin : g_slot
        assign w_fill[k] = w_accept && (w_bcast || SEL == 2'(k));

        slot_reg #(.W(W)) u_slot (
            .clk       (CLK),
            .rst       (RST),
            .fill      (w_fill[k]),
            .fill_data (IN_DATA),
            .out_ready (OUT_READY[k]),
            .data      (w_data[k]),
            .valid     (w_valid[k]),
            .free      (w_free[k])
        );
    end

    // A stalled source must hold its word, destination and mode steady.
    assign w_mismatch = (IN_DATA != r_hold_data) ||
                        (SEL != r_hold_sel) ||
                        (MODE != r_hold_mode);

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_err_set   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (IN_VALID && !w_in_ready) begin
                    w_state_nxt = ST_HOLD;
                    w_capture   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!IN_VALID) begin
                    w_state_nxt = ST_IDLE;
                    w_err_set   = 1'b1;
                end else begin
                    w_err_set = w_mismatch;
                    if (w_accept) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_hold_data <= '0;
            r_hold_sel  <= '0;
            r_hold_mode <= MODE_ADDR;
            r_prot_err  <= 1'b0;
            r_acc_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_hold_data <= IN_DATA;
                r_hold_sel  <= SEL;
                r_hold_mode <= MODE;
            end
            if (w_err_set) begin
                r_prot_err <= 1'b1;
            end
            if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + 1'b1;
            end
        end
    end

    assign IN_READY  = w_in_ready;
    assign OUT_VALID = w_valid;
    assign OUT_DATA0 = w_data[SLOT_DISP];
    assign OUT_DATA1 = w_data[SLOT_FLAG];
    assign OUT_DATA2 = w_data[SLOT_ACC];
    assign OUT_DATA3 = w_data[SLOT_DBG];
    assign ACC_CNT   = r_acc_cnt;
    assign PROT_ERR  = r_prot_err;

endmodule

// File: tb/tb_demux_4ch_reg.sv
// Directed bench for demux_4ch_reg with a per-cycle behavioural model.
module tb_demux_4ch_reg;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] IN_DATA;
    logic       IN_VALID;
    logic       IN_READY;
    logic [1:0] SEL;
    logic       MODE;
    logic [3:0] OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3;
    logic [3:0] OUT_VALID;
    logic [3:0] OUT_READY;
    logic [7:0] ACC_CNT;
    logic       PROT_ERR;

    demux_4ch_reg #(.W(4), .CNT_W(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .SEL       (SEL),
        .MODE      (MODE),
        .OUT_DATA0 (OUT_DATA0),
        .OUT_DATA1 (OUT_DATA1),
        .OUT_DATA2 (OUT_DATA2),
        .OUT_DATA3 (OUT_DATA3),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ACC_CNT   (ACC_CNT),
        .PROT_ERR  (PROT_ERR)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: slot contents, counter, stall tracking.
    bit   [3:0] m_valid;
    logic [3:0] m_data [4];
    logic [7:0] m_cnt;
    bit         m_err;
    bit         m_hold;
    logic [3:0] h_data;
    logic [1:0] h_sel;
    logic       h_mode;

    function automatic bit m_ready();
        bit all_free;
        if (RST) return 1'b0;
        all_free = 1'b1;
        for (int k = 0; k < 4; k++)
            if (m_valid[k] && !OUT_READY[k]) all_free = 1'b0;
        if (MODE) return all_free;
        return !m_valid[SEL] || OUT_READY[SEL];
    endfunction

    always @(posedge CLK or posedge RST) begin : model
        bit acc;
        if (RST) begin
            m_valid = '0;
            for (int k = 0; k < 4; k++) m_data[k] = '0;
            m_cnt  = '0;
            m_err  = 1'b0;
            m_hold = 1'b0;
        end else begin
            acc = IN_VALID && m_ready();
            if (m_hold) begin
                if (!IN_VALID) begin
                    m_err  = 1'b1;
                    m_hold = 1'b0;
                end else begin
                    if (IN_DATA != h_data || SEL != h_sel || MODE != h_mode)
                        m_err = 1'b1;
                    if (acc) m_hold = 1'b0;
                end
            end else if (IN_VALID && !acc) begin
                m_hold = 1'b1;
                h_data = IN_DATA;
                h_sel  = SEL;
                h_mode = MODE;
            end
            for (int k = 0; k < 4; k++) begin
                if (acc && (MODE || SEL == 2'(k))) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = IN_DATA;
                end else if (OUT_READY[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
            if (acc) m_cnt = m_cnt + 8'd1;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cyc_in_ready", IN_READY, m_ready());
            chk("cyc_out_valid", OUT_VALID, m_valid);
            chk("cyc_data0", OUT_DATA0, m_data[0]);
            chk("cyc_data1", OUT_DATA1, m_data[1]);
            chk("cyc_data2", OUT_DATA2, m_data[2]);
            chk("cyc_data3", OUT_DATA3, m_data[3]);
            chk("cyc_acc_cnt", ACC_CNT, m_cnt);
            chk("cyc_prot_err", PROT_ERR, m_err);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b1; IN_DATA = '0;
        SEL = 2'd0; MODE = 1'b0; OUT_READY = '0;
        repeat (2) cyc();
        chk_en = 1'b1;
        @(negedge CLK);
        chk("rst_valid", OUT_VALID, 4'b0000);
        chk("rst_cnt", ACC_CNT, 8'd0);
        chk("rst_err", PROT_ERR, 1'b0);
        chk("rst_ready", IN_READY, 1'b0);

        // Addressed write after reset
        cyc(); RST = 1'b0; MODE = 1'b0; SEL = 2'd2; IN_DATA = 4'hA;
        @(negedge CLK); chk("wr_ready", IN_READY, 1'b1);
        cyc(); IN_VALID = 1'b0;
        @(negedge CLK);
        chk("wr_valid", OUT_VALID, 4'b0100);
        chk("wr_data2", OUT_DATA2, 4'hA);
        chk("wr_cnt", ACC_CNT, 8'd1);

        // Backpressure on slot 2
        cyc(); IN_DATA = 4'h5; IN_VALID = 1'b1;
        @(negedge CLK); chk("bp_ready0", IN_READY, 1'b0);
        cyc();
        @(negedge CLK);
        chk("bp_err", PROT_ERR, 1'b0);
        chk("bp_data_old", OUT_DATA2, 4'hA);
        cyc(); OUT_READY = 4'b0100;
        @(negedge CLK); chk("bp_ready1", IN_READY, 1'b1);
        cyc(); IN_VALID = 1'b0; OUT_READY = '0;
        @(negedge CLK);
        chk("bp_data_new", OUT_DATA2, 4'h5);
        chk("bp_valid", OUT_VALID, 4'b0100);
        chk("bp_cnt", ACC_CNT, 8'd2);

        // Broadcast blocked by slot 1
        cyc(); SEL = 2'd1; IN_DATA = 4'h9; IN_VALID = 1'b1;
        @(negedge CLK); chk("bc_pre_ready", IN_READY, 1'b1);
        cyc(); MODE = 1'b1; IN_DATA = 4'h3; OUT_READY = 4'b0100;
        @(negedge CLK);
        chk("bc_ready0", IN_READY, 1'b0);
        chk("bc_valid0", OUT_VALID, 4'b0110);
        cyc(); OUT_READY = 4'b0010;
        @(negedge CLK);
        chk("bc_ready1", IN_READY, 1'b1);
        chk("bc_valid1", OUT_VALID, 4'b0010);
        cyc(); IN_VALID = 1'b0; OUT_READY = '0; MODE = 1'b0;
        @(negedge CLK);
        chk("bc_valid", OUT_VALID, 4'b1111);
        chk("bc_d0", OUT_DATA0, 4'h3);
        chk("bc_d1", OUT_DATA1, 4'h3);
        chk("bc_d2", OUT_DATA2, 4'h3);
        chk("bc_d3", OUT_DATA3, 4'h3);
        chk("bc_cnt", ACC_CNT, 8'd4);
        chk("bc_err", PROT_ERR, 1'b0);

        // Word changed during a stall
        cyc(); SEL = 2'd0; IN_DATA = 4'h7; IN_VALID = 1'b1;
        @(negedge CLK); chk("pe_ready", IN_READY, 1'b0);
        cyc(); IN_DATA = 4'h8;
        @(negedge CLK); chk("pe_err0", PROT_ERR, 1'b0);
        cyc();
        @(negedge CLK); chk("pe_err1", PROT_ERR, 1'b1);
        cyc(); OUT_READY = 4'b0001;
        @(negedge CLK); chk("pe_ready1", IN_READY, 1'b1);
        cyc(); IN_VALID = 1'b0; OUT_READY = '0;
        @(negedge CLK);
        chk("pe_err2", PROT_ERR, 1'b1);
        chk("pe_data0", OUT_DATA0, 4'h8);
        chk("pe_cnt", ACC_CNT, 8'd5);
        repeat (3) cyc();
        @(negedge CLK); chk("pe_sticky", PROT_ERR, 1'b1);
        cyc(); RST = 1'b1;
        @(negedge CLK);
        chk("pe_cleared", PROT_ERR, 1'b0);
        chk("pe_rst_cnt", ACC_CNT, 8'd0);
        cyc(); RST = 1'b0;

        // 256 back-to-back accepts to slot 3
        SEL = 2'd3; MODE = 1'b0; OUT_READY = 4'b1000; IN_VALID = 1'b1;
        for (int i = 0; i < 256; i++) begin
            IN_DATA = 4'(i);
            cyc();
        end
        IN_VALID = 1'b0; OUT_READY = '0;
        @(negedge CLK);
        chk("wrap_cnt", ACC_CNT, 8'd0);
        chk("wrap_data3", OUT_DATA3, 4'hF);
        chk("wrap_valid", OUT_VALID, 4'b1000);

        // Asynchronous reset with slots 0, 1, 3 occupied
        cyc(); SEL = 2'd0; IN_DATA = 4'h1; IN_VALID = 1'b1;
        cyc(); SEL = 2'd1; IN_DATA = 4'h2;
        cyc(); IN_VALID = 1'b0;
        @(negedge CLK);
        chk("ar_pre_valid", OUT_VALID, 4'b1011);
        chk("ar_pre_cnt", ACC_CNT, 8'd2);
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("ar_valid", OUT_VALID, 4'b0000);
        chk("ar_cnt", ACC_CNT, 8'd0);
        chk("ar_data3", OUT_DATA3, 4'h0);
        cyc(); RST = 1'b0; SEL = 2'd1; IN_DATA = 4'h6; IN_VALID = 1'b1;
        cyc(); IN_VALID = 1'b0;
        @(negedge CLK);
        chk("post_valid", OUT_VALID, 4'b0010);
        chk("post_data1", OUT_DATA1, 4'h6);
        chk("post_cnt", ACC_CNT, 8'd1);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_4ch_reg.md
Name: demux_4ch_reg

Overview:
- Registered 1-to-4 demultiplexer: steers one W-bit source word into one of four output slots, or into all four at once.
- Each slot is a one-entry holding register with its own valid/ready handshake.
- Sits between the 4-bit ALU result path and four downstream consumers (display, flags, accumulator, debug tap).

Parameters:
- W, 4, data width of input word and of each output slot.
- CNT_W, 8, width of the accepted-transfer counter.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_DATA  input  W  source word.
- IN_VALID  input  1  source word is present.
- IN_READY  output  1  the block accepts IN_DATA this cycle.
- SEL  input  2  destination slot in addressed mode.
- MODE  input  1  0 = addressed (SEL), 1 = broadcast to all four slots.
- OUT_DATA0..OUT_DATA3  output  W each  slot holding registers.
- OUT_VALID  output  4  bit k: slot k holds an undelivered word.
- OUT_READY  input  4  bit k: consumer k takes slot k this cycle.
- ACC_CNT  output  CNT_W  count of accepted input transfers.
- PROT_ERR  output  1  sticky flag: protocol violation on the source side.

Behaviour:
- Reset (async, on RST=1):
  - OUT_VALID=0, OUT_DATA0..3=0, ACC_CNT=0, PROT_ERR=0.
  - The internal hold register is cleared.
  - No transfer completes while RST=1.
- Slot k is "free" when OUT_VALID[k]=0, or when OUT_VALID[k]=1 and OUT_READY[k]=1 (it drains this cycle).
- IN_READY is combinational. It is never asserted during RST.
  - MODE=0: IN_READY = free(SEL).
  - MODE=1: IN_READY = free(0) & free(1) & free(2) & free(3).
- Accept = IN_VALID & IN_READY, sampled on the CLK rising edge.
- On accept with MODE=0:
  - OUT_DATA[SEL] <= IN_DATA and OUT_VALID[SEL] <= 1.
  - Other slots are unaffected, apart from their own drains.
- On accept with MODE=1: all four OUT_DATAk <= IN_DATA and OUT_VALID <= 4'b1111.
- Drain: OUT_VALID[k] & OUT_READY[k] with no fill of k that cycle clears OUT_VALID[k]. OUT_DATAk holds its last value.
- Simultaneous drain and fill of the same slot: the slot stays valid and the new word replaces the old one. Zero bubble, so full throughput of 1 word/cycle per slot.
- OUT_READY[k] while OUT_VALID[k]=0 has no effect.
- Latency: an accepted word is visible on OUT_DATAk / OUT_VALID[k] one cycle after the accept edge.
- ACC_CNT: +1 per accept; a broadcast counts once. Wraps from 2^CNT_W-1 to 0 with no flag.
- Source-side tracking uses two states, IDLE and HOLD:
  - IDLE -> HOLD when IN_VALID=1 and IN_READY=0. On that transition, capture IN_DATA, SEL and MODE into the hold register.
  - HOLD -> IDLE on accept, or if IN_VALID drops. Dropping IN_VALID is itself a violation and sets PROT_ERR.
  - In HOLD, if IN_DATA, SEL or MODE differ from the held values, set PROT_ERR.
  - The transfer still follows the live inputs.
- PROT_ERR is cleared only by RST.
- Reset mid-operation: pending slot contents are discarded and the FSM goes to IDLE. The first post-reset accept writes normally.

Decomposition:
- Shared package:
  - MODE_ADDR=1'b0, MODE_BCAST=1'b1.
  - FSM state encodings ST_IDLE, ST_HOLD.
  - Slot index constants SLOT_DISP=0, SLOT_FLAG=1, SLOT_ACC=2, SLOT_DBG=3.
- One sub-module, slot_reg: a single W-bit holding register with valid/ready. Inputs: fill, fill_data, out_ready. Outputs: data, valid, free.
- The top instantiates four slot_reg, the ready/select logic, the FSM and the counter.

Test Plan:
- Reset then addressed write: RST pulse, MODE=0, SEL=2, IN_DATA=4'hA, IN_VALID=1, all OUT_READY=0 -> IN_READY=1. Next cycle OUT_VALID=4'b0100, OUT_DATA2=4'hA, ACC_CNT=1.
- Backpressure: slot 2 full, OUT_READY[2]=0, new word 4'h5 to SEL=2 -> IN_READY=0 and the word is held with PROT_ERR=0. Raise OUT_READY[2] -> same-cycle accept, OUT_DATA2=4'h5 with OUT_VALID[2] continuously 1.
- Broadcast: MODE=1, IN_DATA=4'h3, slot 1 full and not ready -> IN_READY=0. Slot 1 drains -> accept, OUT_VALID=4'b1111, all OUT_DATAk=4'h3, ACC_CNT +1 only.
- Protocol error: stall on SEL=0, change IN_DATA from 4'h7 to 4'h8 while IN_VALID=1, IN_READY=0 -> PROT_ERR=1. It stays 1 after the transfer and clears only on RST.
- Counter wrap: 256 back-to-back accepts to SEL=3 with OUT_READY[3]=1 -> one word per cycle and ACC_CNT returns to 0. The last word is on OUT_DATA3.
- Async reset mid-transfer: assert RST between clock edges while OUT_VALID=4'b1011 -> OUT_VALID=0 and ACC_CNT=0 immediately, with no edge required.
